// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - data-memory responder with wait states and registered write-back bundle
module data_mem_resp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              wb_en_i,
    input  logic [4:0]        wb_addr_i,
    output logic              stall_o,
    output logic              wb_en_o,
    output logic [4:0]        wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam bit       LAT_ZERO = (LATENCY == 0);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              mem_req;
    logic              access;
    logic              bubble;
    logic              is_load;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] ram [2**ADDR_W];

    // Byte-offset and aliased upper address bits are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[1:0], addr_i[DATA_W-1:ADDR_W+2]};

    assign mem_req = rd_en_i | wr_en_i;
    assign idx     = addr_i[ADDR_W+1:2];
    assign is_load = access & rd_en_i & ~wr_en_i;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        access     = 1'b0;
        bubble     = 1'b0;
        stall_o    = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_req) begin
                    if (LAT_ZERO) begin
                        access = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = LAT_M1;
                        bubble     = 1'b1;
                        stall_o    = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                    bubble   = 1'b1;
                    stall_o  = 1'b1;
                end else begin
                    access     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (access && wr_en_i) begin
            ram[idx] <= wdata_i;
        end
    end

    // Bubbles only kill the enable; address/data hold their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_o   <= 1'b0;
            wb_addr_o <= 5'd0;
            wb_data_o <= '0;
        end else if (bubble) begin
            wb_en_o <= 1'b0;
        end else begin
            wb_en_o   <= wb_en_i;
            wb_addr_o <= wb_addr_i;
            wb_data_o <= is_load ? ram[idx] : addr_i;
        end
    end

endmodule
